fibonacci_generator: RTL and testbench

Free-running Fibonacci sequence source with an overflow flag. It sits as a standalone stimulus/pattern block. On each enabled clock edge it advances one term of F(0)=0, F(1)=1, F(n)=F(n-1)+F(n-2). When the next term no longer fits the output width, it stops at the last representable term and raises a sticky overflow flag.

---
 rtl/fibonacci_generator_pkg.sv | 9 +
 rtl/fibonacci_generator.sv | 49 ++++
 tb/tb_fibonacci_generator.sv | 136 +++++++++++++
 3 files changed

// File: rtl/fibonacci_generator_pkg.sv
// Shared constants for the Fibonacci sequence source: default width and the
// reset/initial terms.
package fibonacci_generator_pkg;

    localparam int unsigned DefaultWidth = 8;
    localparam int unsigned InitCur      = 0;
    localparam int unsigned InitNxt      = 1;

endpackage

// File: rtl/fibonacci_generator.sv
// Free-running Fibonacci term source. It freezes at the last representable
// term and raises a sticky overflow flag.
module fibonacci_generator
    import fibonacci_generator_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enble,
    output logic [WIDTH-1:0] fib_out,
    output logic             overflow
);

    localparam logic [WIDTH:0] MaxTerm = {1'b0, {WIDTH{1'b1}}};

    // The initializers match the reset values, so the block behaves the same
    // when it is never reset.
    logic [WIDTH-1:0] r_cur = WIDTH'(InitCur);
    logic [WIDTH:0]   r_nxt = (WIDTH + 1)'(InitNxt);
    logic             r_ovf = 1'b0;

    logic           w_fits;
    logic [WIDTH:0] w_sum;

    // The sum cannot wrap. It is only used when both operands are at most
    // 2^WIDTH-1.
    assign w_fits = (r_nxt <= MaxTerm);
    assign w_sum  = {1'b0, r_cur} + r_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur <= WIDTH'(InitCur);
            r_nxt <= (WIDTH + 1)'(InitNxt);
            r_ovf <= 1'b0;
        end else if (enble && !r_ovf) begin
            if (w_fits) begin
                r_cur <= r_nxt[WIDTH-1:0];
                r_nxt <= w_sum;
            end else begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign fib_out  = r_cur;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_fibonacci_generator.sv
// Directed bench for fibonacci_generator. It uses three instances: a main
// WIDTH=8 instance, a WIDTH=8 instance that is never reset, and a WIDTH=4
// instance.
module tb_fibonacci_generator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a = 1'b1, en_a = 1'b0;
    logic [7:0] fib_a;
    logic       ovf_a;

    logic       rst_b = 1'b0, en_b = 1'b1;
    logic [7:0] fib_b;
    logic       ovf_b;

    logic       rst_c = 1'b1, en_c = 1'b0;
    logic [3:0] fib_c;
    logic       ovf_c;

    int n_tests = 0;
    int n_fail  = 0;

    fibonacci_generator #(.WIDTH(8)) u_dut_a (
        .clk      (clk),
        .rst      (rst_a),
        .enble    (en_a),
        .fib_out  (fib_a),
        .overflow (ovf_a)
    );

    fibonacci_generator #(.WIDTH(8)) u_dut_b (
        .clk      (clk),
        .rst      (rst_b),
        .enble    (en_b),
        .fib_out  (fib_b),
        .overflow (ovf_b)
    );

    fibonacci_generator #(.WIDTH(4)) u_dut_c (
        .clk      (clk),
        .rst      (rst_c),
        .enble    (en_c),
        .fib_out  (fib_c),
        .overflow (ovf_c)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    int unsigned exp8[15] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 233, 233};
    int unsigned exp4[9]  = '{1, 1, 2, 3, 5, 8, 13, 13, 13};

    initial begin
        // Instance b is never reset and is enabled from time 0.
        for (int i = 0; i < 15; i++) begin
            tick();
            check($sformatf("noreset_fib[%0d]", i + 1), fib_b, exp8[i]);
            check($sformatf("noreset_ovf[%0d]", i + 1), ovf_b, (i >= 13) ? 1 : 0);
        end
        en_b = 1'b0;

        // Main instance: check the reset state, then run the full sequence into overflow.
        tick();
        check("reset_fib", fib_a, 0);
        check("reset_ovf", ovf_a, 0);
        rst_a = 1'b0;
        en_a  = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            check($sformatf("seq_fib[%0d]", i + 1), fib_a, exp8[i]);
            check($sformatf("seq_ovf[%0d]", i + 1), ovf_a, (i >= 13) ? 1 : 0);
        end

        // Reset after overflow.
        en_a  = 1'b0;
        rst_a = 1'b1;
        tick();
        check("post_ovf_reset_fib", fib_a, 0);
        check("post_ovf_reset_ovf", ovf_a, 0);
        rst_a = 1'b0;
        en_a  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("restart_fib[%0d]", i + 1), fib_a, exp8[i]);
        end

        // Enable gap at 21.
        en_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("gap_hold[%0d]", i), fib_a, 21);
        end
        en_a = 1'b1;
        tick();
        check("resume_34", fib_a, 34);
        tick();
        check("resume_55", fib_a, 55);
        tick();
        check("resume_89", fib_a, 89);

        // Reset and enable on the same edge: reset wins.
        rst_a = 1'b1;
        tick();
        check("rst_en_fib", fib_a, 0);
        check("rst_en_ovf", ovf_a, 0);
        rst_a = 1'b0;
        tick();
        check("rst_en_next", fib_a, 1);

        // WIDTH=4 instance.
        tick();
        check("w4_reset_fib", fib_c, 0);
        rst_c = 1'b0;
        en_c  = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            check($sformatf("w4_fib[%0d]", i + 1), fib_c, exp4[i]);
            check($sformatf("w4_ovf[%0d]", i + 1), ovf_c, (i >= 7) ? 1 : 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
